mem_0: RTL and testbench
========================

MEM_0 -- requirements
Module: mem_0

Interface
REQ-001 clock  in  1  single clock; all state on posedge.
REQ-002 reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-003 ex_m0_valid  in  1  execute stage presents an instruction.
REQ-004 ex_m0_oper  in  1  instruction is a real operation (0 = bubble).
REQ-005 ex_m0_readmem / ex_m0_writemem  in  1 each  load / store request.
REQ-006 ex_m0_alu_result  in  32  effective byte address or ALU writeback value.
REQ-007 ex_m0_regb  in  32  store data.
REQ-008 ex_m0_regdest  in  5; ex_m0_writereg  in  1  destination register and its enable.
REQ-009 ex_m0_flush  in  1  squash the incoming instruction.
REQ-010 m0_ex_ready  out  1  combinational; 1 = this cycle's ex_m0 input is accepted.
REQ-011 m0_m1_oper, m0_m1_readmem, m0_m1_writemem, m0_m1_writereg  out  1 each  registered.
REQ-012 m0_m1_data_addr  out  32; m0_m1_regb  out  32; m0_m1_regdest  out  5  registered.
REQ-013 m0_err  out  1  sticky access-error flag; m0_err_addr  out  32  address of the first faulting access.
REQ-014 m0_bubble_cnt  out  8  saturating count of inserted hazard bubbles.

Function
REQ-015 An instruction transfers when ex_m0_valid & m0_ex_ready; its fields appear on m0_m1_* one cycle later (latency 1).
REQ-016 When no transfer occurs, m0_m1_* are loaded with a bubble: all fields 0, oper 0.
REQ-017 A request with readmem & writemem both 1 is treated as a load; writemem is forced to 0 on m0_m1_writemem.
REQ-018 Hazard = ex_m0_valid & ex_m0_oper & ex_m0_readmem & m0_m1_oper & m0_m1_writemem & (ex_m0_alu_result[8:2] == m0_m1_data_addr[8:2]).
REQ-019 FSM states are RUN and BUBBLE; reset state is RUN.
REQ-020 RUN with hazard: m0_ex_ready=0, output register takes a bubble, m0_bubble_cnt increments (saturating at 255), next state BUBBLE.
REQ-021 RUN without hazard: m0_ex_ready=1, stay in RUN.
REQ-022 BUBBLE: m0_ex_ready=1 unconditionally, the held load is accepted, next state RUN.
REQ-023 ex_m0_flush=1: m0_ex_ready=1, the output register takes a bubble, next state RUN, no counter change; flush has priority over hazard and over the BUBBLE state.
REQ-024 Non-memory instructions (readmem=writemem=0) pass through unchanged; the alu_result appears on m0_m1_data_addr.

Reset
REQ-025 On reset: all m0_m1_* = 0, m0_err=0, m0_err_addr=0, m0_bubble_cnt=0, state RUN.
REQ-026 Reset asserted during BUBBLE abandons the held load; m0_ex_ready=1 from the first cycle after release.

Configuration
REQ-027 Macro MEM_0_ACCESS_CHECK_EN: when defined, a memory access with addr[1:0]!=0 or addr[31:9]!=0 is faulting.
REQ-028 A faulting access forwards with readmem, writemem and writereg forced to 0 and oper kept.
REQ-029 The first faulting access sets m0_err=1 and captures m0_err_addr; later faults do not overwrite either until reset.
REQ-030 When the macro is undefined, no checking is performed, m0_err and m0_err_addr are tied to 0, and addresses pass unmodified.

Structure
REQ-031 The shared package holds the FSM state encoding, the RAM word-index range [8:2], and the bubble-counter width constant.
REQ-032 The access checker is a sub-module, mem_0_addr_check (combinational fault decode); the FSM and the pipeline register stay in mem_0.

Verification
REQ-033 Store to 0x40, then load from 0x40 on the next cycle -> m0_ex_ready=0 for 1 cycle, one bubble on m0_m1, load emitted 2 cycles after the store, m0_bubble_cnt=1.
REQ-034 Store to 0x40, then load from 0x44 -> no stall; the load is emitted on the cycle after the store.
REQ-035 256 back-to-back store-to-load hazards -> m0_bubble_cnt saturates at 255.
REQ-036 Flush asserted during the hazard cycle -> m0_ex_ready=1, bubble emitted, state RUN, m0_bubble_cnt unchanged.
REQ-037 With MEM_0_ACCESS_CHECK_EN: load from 0x42, then store to 0x400 -> m0_err=1, m0_err_addr=0x42, both emitted with readmem=writemem=writereg=0.
REQ-038 Reset pulsed during BUBBLE -> all outputs 0 asynchronously; the next valid load passes with latency 1.

Source files
------------

// File: rtl/mem_0_pkg.sv
// Shared types and constants for the mem_0 pipeline stage.
// The optional access checker is enabled by defining MEM_0_ACCESS_CHECK_EN.
package mem_0_pkg;

   typedef enum logic [0:0] {
      ST_RUN    = 1'b0,
      ST_BUBBLE = 1'b1
   } state_t;

   localparam int WORD_IDX_HI  = 8;
   localparam int WORD_IDX_LO  = 2;
   localparam int BUBBLE_CNT_W = 8;
   localparam logic [BUBBLE_CNT_W-1:0] BUBBLE_CNT_MAX = '1;

`ifdef MEM_0_ACCESS_CHECK_EN
   localparam bit ACCESS_CHECK_EN = 1'b1;
`else
   localparam bit ACCESS_CHECK_EN = 1'b0;
`endif

   typedef struct packed {
      logic        oper;
      logic        readmem;
      logic        writemem;
      logic        writereg;
      logic [31:0] data_addr;
      logic [31:0] regb;
      logic [4:0]  regdest;
   } m1_t;

endpackage

// File: rtl/mem_0_addr_check.sv
// Combinational fault decode for memory accesses: misaligned or outside the RAM window.
// Reports no faults unless MEM_0_ACCESS_CHECK_EN is defined.
module mem_0_addr_check
   import mem_0_pkg::*;
(
   input  logic        oper,
   input  logic        readmem,
   input  logic        writemem,
   input  logic [31:0] addr,
   output logic        fault
);

   logic bad_addr;

   assign bad_addr = (addr[1:0] != 2'b00) || (addr[31:WORD_IDX_HI+1] != '0);
   assign fault    = ACCESS_CHECK_EN && oper && (readmem || writemem) && bad_addr;

endmodule

// File: rtl/mem_0.sv
// MEM0 pipeline stage: registers EX results toward MEM1 and inserts one bubble on a store-to-load hazard.
// MEM_0_ACCESS_CHECK_EN adds address fault checking and the sticky error capture.
//
// Handshake: an ex_m0 instruction is taken in any cycle where ex_m0_valid && m0_ex_ready;
// m0_ex_ready is combinational and EX must hold its instruction while it is low.
module mem_0
   import mem_0_pkg::*;
(
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    ex_m0_valid,
   input  logic                    ex_m0_oper,
   input  logic                    ex_m0_readmem,
   input  logic                    ex_m0_writemem,
   input  logic [31:0]             ex_m0_alu_result,
   input  logic [31:0]             ex_m0_regb,
   input  logic [4:0]              ex_m0_regdest,
   input  logic                    ex_m0_writereg,
   input  logic                    ex_m0_flush,
   output logic                    m0_ex_ready,
   output logic                    m0_m1_oper,
   output logic                    m0_m1_readmem,
   output logic                    m0_m1_writemem,
   output logic                    m0_m1_writereg,
   output logic [31:0]             m0_m1_data_addr,
   output logic [31:0]             m0_m1_regb,
   output logic [4:0]              m0_m1_regdest,
   output logic                    m0_err,
   output logic [31:0]             m0_err_addr,
   output logic [BUBBLE_CNT_W-1:0] m0_bubble_cnt,
   output state_t                  m0_state
);

   state_t                  state_q, state_d;
   m1_t                     m1_q, m1_d;
   logic [BUBBLE_CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
   logic                    hazard;
   logic                    stall;
   logic                    transfer;
   logic                    fault;

   mem_0_addr_check u_addr_check (
      .oper     (ex_m0_oper),
      .readmem  (ex_m0_readmem),
      .writemem (ex_m0_writemem),
      .addr     (ex_m0_alu_result),
      .fault    (fault)
   );

   // A load reading the word the previous store is writing must wait one cycle.
   always_comb begin
      hazard = ex_m0_valid && ex_m0_oper && ex_m0_readmem && m1_q.oper && m1_q.writemem &&
               (ex_m0_alu_result[WORD_IDX_HI:WORD_IDX_LO] == m1_q.data_addr[WORD_IDX_HI:WORD_IDX_LO]);
      stall       = (state_q == ST_RUN) && hazard && !ex_m0_flush;
      m0_ex_ready = !stall;
      transfer    = ex_m0_valid && !stall && !ex_m0_flush;
   end

   always_comb begin
      m1_d = '0;
      if (transfer) begin
         m1_d.oper      = ex_m0_oper;
         m1_d.readmem   = ex_m0_readmem && !fault;
         m1_d.writemem  = ex_m0_writemem && !ex_m0_readmem && !fault;
         m1_d.writereg  = ex_m0_writereg && !fault;
         m1_d.data_addr = ex_m0_alu_result;
         m1_d.regb      = ex_m0_regb;
         m1_d.regdest   = ex_m0_regdest;
      end

      state_d      = stall ? ST_BUBBLE : ST_RUN;
      bubble_cnt_d = bubble_cnt_q;
      if (stall && (bubble_cnt_q != BUBBLE_CNT_MAX)) begin
         bubble_cnt_d = bubble_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q      <= ST_RUN;
         m1_q         <= '0;
         bubble_cnt_q <= '0;
      end else begin
         state_q      <= state_d;
         m1_q         <= m1_d;
         bubble_cnt_q <= bubble_cnt_d;
      end
   end

`ifdef MEM_0_ACCESS_CHECK_EN
   logic        err_q, err_d;
   logic [31:0] err_addr_q, err_addr_d;

   // Only the first fault is recorded; later ones leave the capture untouched.
   always_comb begin
      err_d      = err_q;
      err_addr_d = err_addr_q;
      if (transfer && fault && !err_q) begin
         err_d      = 1'b1;
         err_addr_d = ex_m0_alu_result;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         err_q      <= 1'b0;
         err_addr_q <= '0;
      end else begin
         err_q      <= err_d;
         err_addr_q <= err_addr_d;
      end
   end

   assign m0_err      = err_q;
   assign m0_err_addr = err_addr_q;
`else
   assign m0_err      = 1'b0;
   assign m0_err_addr = '0;
`endif

   assign m0_m1_oper      = m1_q.oper;
   assign m0_m1_readmem   = m1_q.readmem;
   assign m0_m1_writemem  = m1_q.writemem;
   assign m0_m1_writereg  = m1_q.writereg;
   assign m0_m1_data_addr = m1_q.data_addr;
   assign m0_m1_regb      = m1_q.regb;
   assign m0_m1_regdest   = m1_q.regdest;
   assign m0_bubble_cnt   = bubble_cnt_q;
   assign m0_state        = state_q;

endmodule

// File: tb/tb_mem_0.sv
// Directed bench for mem_0: hazard bubble, flush, reset during BUBBLE, saturation, access checking.
module tb_mem_0;
   import mem_0_pkg::*;

   logic        clock;
   logic        reset;
   logic        ex_m0_valid, ex_m0_oper, ex_m0_readmem, ex_m0_writemem;
   logic [31:0] ex_m0_alu_result, ex_m0_regb;
   logic [4:0]  ex_m0_regdest;
   logic        ex_m0_writereg, ex_m0_flush;
   logic        m0_ex_ready;
   logic        m0_m1_oper, m0_m1_readmem, m0_m1_writemem, m0_m1_writereg;
   logic [31:0] m0_m1_data_addr, m0_m1_regb;
   logic [4:0]  m0_m1_regdest;
   logic        m0_err;
   logic [31:0] m0_err_addr;
   logic [7:0]  m0_bubble_cnt;
   state_t      m0_state;

   int n_tests;
   int n_fail;

   mem_0 dut (
      .clock            (clock),
      .reset            (reset),
      .ex_m0_valid      (ex_m0_valid),
      .ex_m0_oper       (ex_m0_oper),
      .ex_m0_readmem    (ex_m0_readmem),
      .ex_m0_writemem   (ex_m0_writemem),
      .ex_m0_alu_result (ex_m0_alu_result),
      .ex_m0_regb       (ex_m0_regb),
      .ex_m0_regdest    (ex_m0_regdest),
      .ex_m0_writereg   (ex_m0_writereg),
      .ex_m0_flush      (ex_m0_flush),
      .m0_ex_ready      (m0_ex_ready),
      .m0_m1_oper       (m0_m1_oper),
      .m0_m1_readmem    (m0_m1_readmem),
      .m0_m1_writemem   (m0_m1_writemem),
      .m0_m1_writereg   (m0_m1_writereg),
      .m0_m1_data_addr  (m0_m1_data_addr),
      .m0_m1_regb       (m0_m1_regb),
      .m0_m1_regdest    (m0_m1_regdest),
      .m0_err           (m0_err),
      .m0_err_addr      (m0_err_addr),
      .m0_bubble_cnt    (m0_bubble_cnt),
      .m0_state         (m0_state)
   );

   // Clock and reset
   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input logic valid, input logic oper, input logic rd, input logic wr,
                        input logic [31:0] addr, input logic [31:0] regb,
                        input logic [4:0] dest, input logic wreg, input logic flush);
      ex_m0_valid      = valid;
      ex_m0_oper       = oper;
      ex_m0_readmem    = rd;
      ex_m0_writemem   = wr;
      ex_m0_alu_result = addr;
      ex_m0_regb       = regb;
      ex_m0_regdest    = dest;
      ex_m0_writereg   = wreg;
      ex_m0_flush      = flush;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
   endtask

   task automatic store(input logic [31:0] addr, input logic [31:0] data);
      drive(1'b1, 1'b1, 1'b0, 1'b1, addr, data, 5'd0, 1'b0, 1'b0);
   endtask

   task automatic load(input logic [31:0] addr, input logic [4:0] dest);
      drive(1'b1, 1'b1, 1'b1, 1'b0, addr, 32'h0, dest, 1'b1, 1'b0);
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      #3;
      reset = 1'b0;
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      reset   = 1'b1;
      idle();
      #12;
      reset = 1'b0;
      step();

      // Reset state
      check("rst_ready", 32'(m0_ex_ready), 32'd1);
      check("rst_oper", 32'(m0_m1_oper), 32'd0);
      check("rst_addr", m0_m1_data_addr, 32'h0);
      check("rst_cnt", 32'(m0_bubble_cnt), 32'd0);
      check("rst_err", 32'(m0_err), 32'd0);
      check("rst_state", 32'(m0_state), 32'(ST_RUN));

      // Store 0x40 then load 0x40: one bubble, load two cycles after store
      store(32'h40, 32'hDEAD_BEEF);
      #1 check("st_ready", 32'(m0_ex_ready), 32'd1);
      step();
      check("st_wr", 32'(m0_m1_writemem), 32'd1);
      check("st_addr", m0_m1_data_addr, 32'h40);
      check("st_regb", m0_m1_regb, 32'hDEAD_BEEF);
      load(32'h40, 5'd3);
      #1 check("haz_ready", 32'(m0_ex_ready), 32'd0);
      step();
      check("haz_bub_oper", 32'(m0_m1_oper), 32'd0);
      check("haz_bub_addr", m0_m1_data_addr, 32'h0);
      check("haz_cnt", 32'(m0_bubble_cnt), 32'd1);
      check("haz_state", 32'(m0_state), 32'(ST_BUBBLE));
      #1 check("bub_ready", 32'(m0_ex_ready), 32'd1);
      step();
      check("ld_rd", 32'(m0_m1_readmem), 32'd1);
      check("ld_addr", m0_m1_data_addr, 32'h40);
      check("ld_dest", 32'(m0_m1_regdest), 32'd3);
      check("ld_wreg", 32'(m0_m1_writereg), 32'd1);
      check("ld_state", 32'(m0_state), 32'(ST_RUN));

      // Store 0x40 then load 0x44: different word, no stall
      store(32'h40, 32'h1111_2222);
      step();
      load(32'h44, 5'd4);
      #1 check("nohaz_ready", 32'(m0_ex_ready), 32'd1);
      step();
      check("nohaz_rd", 32'(m0_m1_readmem), 32'd1);
      check("nohaz_addr", m0_m1_data_addr, 32'h44);
      check("nohaz_cnt", 32'(m0_bubble_cnt), 32'd1);

      // Read and write both set is a load
      drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h80, 32'h5, 5'd9, 1'b1, 1'b0);
      step();
      check("rw_rd", 32'(m0_m1_readmem), 32'd1);
      check("rw_wr", 32'(m0_m1_writemem), 32'd0);

      // Non-memory op passes through
      drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h1234_5678, 32'hA5A5_0000, 5'd7, 1'b1, 1'b0);
      step();
      check("alu_addr", m0_m1_data_addr, 32'h1234_5678);
      check("alu_dest", 32'(m0_m1_regdest), 32'd7);
      check("alu_wreg", 32'(m0_m1_writereg), 32'd1);
      check("alu_regb", m0_m1_regb, 32'hA5A5_0000);

      // No transfer loads a bubble
      idle();
      step();
      check("idle_oper", 32'(m0_m1_oper), 32'd0);
      check("idle_wreg", 32'(m0_m1_writereg), 32'd0);
      check("idle_addr", m0_m1_data_addr, 32'h0);

      // Flush during hazard cycle
      store(32'h40, 32'h0);
      step();
      drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h40, 32'h0, 5'd2, 1'b1, 1'b1);
      #1 check("fl_ready", 32'(m0_ex_ready), 32'd1);
      step();
      check("fl_oper", 32'(m0_m1_oper), 32'd0);
      check("fl_rd", 32'(m0_m1_readmem), 32'd0);
      check("fl_cnt", 32'(m0_bubble_cnt), 32'd1);
      check("fl_state", 32'(m0_state), 32'(ST_RUN));

      // Reset pulsed during BUBBLE
      store(32'h40, 32'h0);
      step();
      load(32'h40, 5'd6);
      step();
      check("rb_state", 32'(m0_state), 32'(ST_BUBBLE));
      check("rb_cnt", 32'(m0_bubble_cnt), 32'd2);
      reset = 1'b1;
      #1;
      check("rb_async_state", 32'(m0_state), 32'(ST_RUN));
      check("rb_async_cnt", 32'(m0_bubble_cnt), 32'd0);
      check("rb_async_oper", 32'(m0_m1_oper), 32'd0);
      #2 reset = 1'b0;
      load(32'h100, 5'd5);
      #1 check("rb_ready", 32'(m0_ex_ready), 32'd1);
      step();
      check("rb_ld_rd", 32'(m0_m1_readmem), 32'd1);
      check("rb_ld_addr", m0_m1_data_addr, 32'h100);
      check("rb_ld_dest", 32'(m0_m1_regdest), 32'd5);

      // Access checking
`ifdef MEM_0_ACCESS_CHECK_EN
      load(32'h42, 5'd8);
      step();
      check("ac_ld_oper", 32'(m0_m1_oper), 32'd1);
      check("ac_ld_rd", 32'(m0_m1_readmem), 32'd0);
      check("ac_ld_wreg", 32'(m0_m1_writereg), 32'd0);
      check("ac_ld_addr", m0_m1_data_addr, 32'h42);
      check("ac_err", 32'(m0_err), 32'd1);
      check("ac_err_addr", m0_err_addr, 32'h42);
      store(32'h400, 32'h77);
      step();
      check("ac_st_oper", 32'(m0_m1_oper), 32'd1);
      check("ac_st_wr", 32'(m0_m1_writemem), 32'd0);
      check("ac_st_addr", m0_m1_data_addr, 32'h400);
      check("ac_err2", 32'(m0_err), 32'd1);
      check("ac_err_addr2", m0_err_addr, 32'h42);
`else
      load(32'h42, 5'd8);
      step();
      check("nc_ld_rd", 32'(m0_m1_readmem), 32'd1);
      check("nc_ld_wreg", 32'(m0_m1_writereg), 32'd1);
      check("nc_ld_addr", m0_m1_data_addr, 32'h42);
      check("nc_err", 32'(m0_err), 32'd0);
      store(32'h400, 32'h77);
      step();
      check("nc_st_wr", 32'(m0_m1_writemem), 32'd1);
      check("nc_err_addr", m0_err_addr, 32'h0);
`endif

      // 256 back-to-back hazards saturate the bubble counter
      pulse_reset();
      for (int i = 0; i < 256; i++) begin
         store(32'h40, 32'(i));
         step();
         load(32'h40, 5'd1);
         step();
         step();
         if (i == 254) check("sat_254", 32'(m0_bubble_cnt), 32'd255);
      end
      check("sat_255", 32'(m0_bubble_cnt), 32'd255);
      check("sat_ld_rd", 32'(m0_m1_readmem), 32'd1);
      idle();
      step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
